// File: rtl/dmem_store_buffer.sv
// rtl/dmem_store_buffer.sv - posted-store FIFO in front of the byte-addressed data memory
// Optional STB_FWD_EN: a load exactly covered by the youngest overlapping word store is forwarded.
module dmem_store_buffer #(
   parameter int DEPTH           = 4,
   parameter int DMEM_ADDR_WIDTH = 12
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       st_valid,
   input  logic [DMEM_ADDR_WIDTH-1:0] st_addr,
   input  logic [1:0]                 st_sz,
   input  logic [31:0]                st_data,
   output logic                       st_ready,
   input  logic                       ld_en,
   input  logic [DMEM_ADDR_WIDTH-1:0] ld_addr,
   input  logic [1:0]                 ld_sz,
   output logic [31:0]                ld_data,
   output logic                       ld_stall,
   output logic                       sb_empty,
   output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
   output logic                       dmem_rd_en,
   output logic                       dmem_wr_en,
   output logic [1:0]                 dmem_sz,
   output logic [31:0]                dmem_din,
   input  logic [31:0]                dmem_dout
);

   localparam int AW = DMEM_ADDR_WIDTH;
   localparam int PW = $clog2(DEPTH);

   logic [AW-1:0] e_addr [DEPTH];
   logic [1:0]    e_sz   [DEPTH];
   logic [31:0]   e_data [DEPTH];

   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [PW:0]   count;
   logic          enq;
   logic          drain;
   logic          hit;
`ifdef STB_FWD_EN
   logic          fwd_ok;
   logic [31:0]   fwd_data;
`endif

   function automatic logic [2:0] nbytes(input logic [1:0] sz);
      case (sz)
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic [31:0] sz_mask(input logic [1:0] sz);
      case (sz)
         2'b00:   return 32'h0000_00ff;
         2'b01:   return 32'h0000_ffff;
         default: return 32'hffff_ffff;
      endcase
   endfunction

   // Modular differences make the top and bottom of the address space adjacent, as in dmem.
   function automatic logic overlaps(input logic [AW-1:0] ea, input logic [1:0] es,
                                     input logic [AW-1:0] la, input logic [1:0] ls);
      logic [AW-1:0] d_le;
      logic [AW-1:0] d_el;
      d_le = la - ea;
      d_el = ea - la;
      return (d_le < AW'(nbytes(es))) || (d_el < AW'(nbytes(ls)));
   endfunction

   assign st_ready = (count != (PW+1)'(DEPTH));
   assign sb_empty = (count == '0);
   assign enq      = st_valid && st_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (enq)   tail <= tail + 1'b1;
         if (drain) head <= head + 1'b1;
         case ({enq, drain})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         e_addr[tail] <= st_addr;
         e_sz[tail]   <= st_sz;
         e_data[tail] <= st_data;
      end
   end

   // Scan oldest to youngest so the last match seen is the youngest overlapping entry.
   always_comb begin
      hit = 1'b0;
`ifdef STB_FWD_EN
      fwd_ok   = 1'b0;
      fwd_data = '0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
         logic [PW-1:0] idx;
         idx = head + PW'(i);
         if (((PW+1)'(i) < count) && overlaps(e_addr[idx], e_sz[idx], ld_addr, ld_sz)) begin
            hit = 1'b1;
`ifdef STB_FWD_EN
            fwd_ok   = e_sz[idx][1] && (e_addr[idx] == ld_addr);
            fwd_data = e_data[idx];
`endif
         end
      end
   end

   always_comb begin
      ld_stall   = 1'b0;
      ld_data    = '0;
      dmem_rd_en = 1'b0;
      dmem_wr_en = 1'b0;
      dmem_addr  = '0;
      dmem_sz    = '0;
      dmem_din   = '0;
      drain      = 1'b0;
      if (!reset) begin
         if (ld_en && !hit) begin
            dmem_rd_en = 1'b1;
            dmem_addr  = ld_addr;
            dmem_sz    = ld_sz;
            ld_data    = dmem_dout & sz_mask(ld_sz);
         end else begin
            if (ld_en) begin
`ifdef STB_FWD_EN
               if (fwd_ok) ld_data  = fwd_data & sz_mask(ld_sz);
               else        ld_stall = 1'b1;
`else
               ld_stall = 1'b1;
`endif
            end
            // A conflicting load always finds count > 0 here, so the forced drain makes progress.
            if (count != '0) begin
               drain      = 1'b1;
               dmem_wr_en = 1'b1;
               dmem_addr  = e_addr[head];
               dmem_sz    = e_sz[head];
               dmem_din   = e_data[head];
            end
         end
      end
   end

endmodule
